// File: rtl/vp_pkg.sv
// Shared types for the value-predictor feedback path.
package vp_pkg;

    localparam int VP_XLEN = 32;

    typedef struct packed {
        logic [VP_XLEN-1:0] pc;
        logic [VP_XLEN-1:0] result;
    } fb_entry_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PAUSE = 2'd1,
        FLUSH = 2'd2
    } fbs_state_t;

endpackage

// File: rtl/vp_fb_fifo.sv
// In-order circular buffer: compacting multi-lane push, multi-entry pop from head,
// synchronous clear. Exposes the first P_NUM_PRED head entries combinationally.
module vp_fb_fifo
    import vp_pkg::*;
#(
    parameter int  P_NUM_PRED   = 2,
    parameter int  P_FIFO_DEPTH = 8,
    localparam int CW = $clog2(P_FIFO_DEPTH + 1),
    localparam int PW = $clog2(P_FIFO_DEPTH),
    localparam int NW = $clog2(P_NUM_PRED + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  push_en_i,
    input  logic [P_NUM_PRED-1:0] push_valid_i,
    input  fb_entry_t             push_data_i [P_NUM_PRED],
    input  logic [NW-1:0]         pop_num_i,
    output fb_entry_t             head_o [P_NUM_PRED],
    output logic [CW-1:0]         count_o
);

    fb_entry_t     mem_q [P_FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [NW-1:0] push_num;
    logic [PW-1:0] wr_idx [P_NUM_PRED];

    // Each valid lane lands after all lower valid lanes, so gaps never reach the buffer.
    always_comb begin
        push_num = '0;
        for (int k = 0; k < P_NUM_PRED; k++) begin
            wr_idx[k] = wr_ptr_q + PW'(push_num);
            if (push_valid_i[k]) begin
                push_num = push_num + NW'(1);
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en_i) begin
                wr_ptr_d = wr_ptr_q + PW'(push_num);
            end
            rd_ptr_d = rd_ptr_q + PW'(pop_num_i);
            count_d  = count_q + (push_en_i ? CW'(push_num) : CW'(0)) - CW'(pop_num_i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < P_NUM_PRED; k++) begin
            if (push_en_i && !clear_i && push_valid_i[k]) begin
                mem_q[wr_idx[k]] <= push_data_i[k];
            end
        end
    end

    for (genvar gi = 0; gi < P_NUM_PRED; gi++) begin : g_head
        assign head_o[gi] = mem_q[rd_ptr_q + PW'(gi)];
    end

    assign count_o = count_q;

endmodule

// File: rtl/vp_fb_scheduler.sv
// Feedback scheduler: buffers commit feedback and issues conflict-free groups to the
// predictor. Optional saturating statistics counters under VP_FBS_STATS_EN.
module vp_fb_scheduler
    import vp_pkg::*;
#(
    parameter int  P_NUM_PRED    = 2,
    parameter int  P_INDEX_WIDTH = 11,
    parameter int  P_FIFO_DEPTH  = 8,
    localparam int CW = $clog2(P_FIFO_DEPTH + 1),
    localparam int NW = $clog2(P_NUM_PRED + 1)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [P_NUM_PRED-1:0][VP_XLEN-1:0] in_pc_i,
    input  logic [P_NUM_PRED-1:0][VP_XLEN-1:0] in_result_i,
    input  logic [P_NUM_PRED-1:0]               in_valid_i,
    output logic                                in_ready_o,
    input  logic                                pause_i,
    input  logic                                flush_i,
    output logic [P_NUM_PRED-1:0][VP_XLEN-1:0] fb_pc_o,
    output logic [P_NUM_PRED-1:0][VP_XLEN-1:0] fb_result_o,
    output logic [P_NUM_PRED-1:0]               fb_valid_o,
`ifdef VP_FBS_STATS_EN
    output logic [31:0]                         conflict_cnt_o,
    output logic [31:0]                         drop_cnt_o,
`endif
    output logic [CW-1:0]                       fifo_count_o
);

    fbs_state_t                          state_q, state_d;
    logic                                issue_en;
    logic                                push_en;
    logic                                conflict;
    logic                                blocked;
    logic                                hit;
    logic [P_NUM_PRED-1:0]               issue_mask;
    logic [NW-1:0]                       pop_num;
    logic [CW-1:0]                       fifo_count;
    fb_entry_t                           push_data [P_NUM_PRED];
    fb_entry_t                           head [P_NUM_PRED];
    logic [P_NUM_PRED-1:0]               fb_valid_q, fb_valid_d;
    logic [P_NUM_PRED-1:0][VP_XLEN-1:0]  fb_pc_q, fb_pc_d;
    logic [P_NUM_PRED-1:0][VP_XLEN-1:0]  fb_result_q, fb_result_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (flush_i) state_d = FLUSH; else if (pause_i) state_d = PAUSE;
            PAUSE:   if (flush_i) state_d = FLUSH; else if (!pause_i) state_d = RUN;
            FLUSH:   state_d = pause_i ? PAUSE : RUN;
            default: state_d = RUN;
        endcase
    end

    // Ready looks only at registered state so it never loops back through in_valid_i.
    always_comb begin
        in_ready_o = (state_q != FLUSH) &&
                     (fifo_count <= CW'(P_FIFO_DEPTH - P_NUM_PRED));
        issue_en   = (state_q == RUN) && !flush_i;
        push_en    = in_ready_o && (|in_valid_i);
    end

    for (genvar gi = 0; gi < P_NUM_PRED; gi++) begin : g_push
        assign push_data[gi] = {in_pc_i[gi], in_result_i[gi]};
    end

    vp_fb_fifo #(
        .P_NUM_PRED   (P_NUM_PRED),
        .P_FIFO_DEPTH (P_FIFO_DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (flush_i),
        .push_en_i    (push_en),
        .push_valid_i (in_valid_i),
        .push_data_i  (push_data),
        .pop_num_i    (pop_num),
        .head_o       (head),
        .count_o      (fifo_count)
    );

    // Issue a strict in-order prefix; the first index collision ends the group.
    always_comb begin
        issue_mask = '0;
        pop_num    = '0;
        blocked    = 1'b0;
        conflict   = 1'b0;
        hit        = 1'b0;
        for (int k = 0; k < P_NUM_PRED; k++) begin
            if (issue_en && !blocked && (CW'(k) < fifo_count)) begin
                hit = 1'b0;
                for (int j = 0; j < k; j++) begin
                    if (head[j].pc[P_INDEX_WIDTH-1:0] == head[k].pc[P_INDEX_WIDTH-1:0]) begin
                        hit = 1'b1;
                    end
                end
                if (hit) begin
                    blocked  = 1'b1;
                    conflict = 1'b1;
                end else begin
                    issue_mask[k] = 1'b1;
                    pop_num       = pop_num + NW'(1);
                end
            end else begin
                blocked = 1'b1;
            end
        end
    end

    always_comb begin
        fb_valid_d  = '0;
        fb_pc_d     = fb_pc_q;
        fb_result_d = fb_result_q;
        for (int k = 0; k < P_NUM_PRED; k++) begin
            if (issue_mask[k]) begin
                fb_valid_d[k]  = 1'b1;
                fb_pc_d[k]     = head[k].pc;
                fb_result_d[k] = head[k].result;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fb_valid_q  <= '0;
            fb_pc_q     <= '0;
            fb_result_q <= '0;
        end else begin
            fb_valid_q  <= fb_valid_d;
            fb_pc_q     <= fb_pc_d;
            fb_result_q <= fb_result_d;
        end
    end

    assign fb_valid_o   = fb_valid_q;
    assign fb_pc_o      = fb_pc_q;
    assign fb_result_o  = fb_result_q;
    assign fifo_count_o = fifo_count;

`ifdef VP_FBS_STATS_EN
    logic [31:0] conflict_cnt_q, conflict_cnt_d;
    logic [31:0] drop_cnt_q, drop_cnt_d;
    logic [32:0] drop_sum;

    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if (conflict && (conflict_cnt_q != '1)) begin
            conflict_cnt_d = conflict_cnt_q + 32'd1;
        end
        drop_sum   = {1'b0, drop_cnt_q} + 33'(fifo_count);
        drop_cnt_d = drop_cnt_q;
        if (flush_i) begin
            drop_cnt_d = drop_sum[32] ? '1 : drop_sum[31:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            conflict_cnt_q <= '0;
            drop_cnt_q     <= '0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
            drop_cnt_q     <= drop_cnt_d;
        end
    end

    assign conflict_cnt_o = conflict_cnt_q;
    assign drop_cnt_o     = drop_cnt_q;
`endif

endmodule

// File: tb/tb_vp_fb_scheduler.sv
// Scoreboard bench for vp_fb_scheduler: queue-based reference model plus an
// independent output monitor; directed scenarios followed by random traffic.
module tb_vp_fb_scheduler;
    import vp_pkg::*;

    localparam int NP    = 2;
    localparam int IW    = 11;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic                  clk_i = 1'b0;
    logic                  rst_i = 1'b1;
    logic [NP-1:0][31:0]   in_pc_i;
    logic [NP-1:0][31:0]   in_result_i;
    logic [NP-1:0]         in_valid_i;
    logic                  in_ready_o;
    logic                  pause_i;
    logic                  flush_i;
    logic [NP-1:0][31:0]   fb_pc_o;
    logic [NP-1:0][31:0]   fb_result_o;
    logic [NP-1:0]         fb_valid_o;
    logic [CW-1:0]         fifo_count_o;
`ifdef VP_FBS_STATS_EN
    logic [31:0]           conflict_cnt_o;
    logic [31:0]           drop_cnt_o;
`endif

    vp_fb_scheduler #(
        .P_NUM_PRED    (NP),
        .P_INDEX_WIDTH (IW),
        .P_FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .in_pc_i      (in_pc_i),
        .in_result_i  (in_result_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .pause_i      (pause_i),
        .flush_i      (flush_i),
        .fb_pc_o      (fb_pc_o),
        .fb_result_o  (fb_result_o),
        .fb_valid_o   (fb_valid_o),
`ifdef VP_FBS_STATS_EN
        .conflict_cnt_o (conflict_cnt_o),
        .drop_cnt_o     (drop_cnt_o),
`endif
        .fifo_count_o (fifo_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] res;
    } ent_t;

    typedef struct {
        int                  tag;
        logic [NP-1:0]       v;
        logic [NP-1:0][31:0] pc;
        logic [NP-1:0][31:0] res;
    } exp_t;

    ent_t        mq [$];
    exp_t        expq [$];
    logic        m_flushing = 1'b0;
    logic        m_paused   = 1'b0;
    int unsigned m_conf     = 0;
    int unsigned m_drop     = 0;
    logic        r_pause    = 1'b0;
    int          edge_cnt   = 0;
    int          n_chk      = 0;
    int          n_err      = 0;

    always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // One cycle: check registered outputs, drive inputs, advance the reference model.
    task automatic step(input logic [NP-1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                        input logic [31:0] r0, input logic [31:0] r1,
                        input logic pz, input logic fl);
        logic exp_ready;
        logic blk;
        int   n_iss;
        ent_t a;
        ent_t b;
        exp_t e;
        @(negedge clk_i);
        exp_ready = !m_flushing && ((DEPTH - mq.size()) >= NP);
        check("in_ready", 32'(in_ready_o), 32'(exp_ready));
        check("fifo_count", 32'(fifo_count_o), mq.size());
`ifdef VP_FBS_STATS_EN
        check("conflict_cnt", conflict_cnt_o, m_conf);
        check("drop_cnt", drop_cnt_o, m_drop);
`endif
        in_valid_i     = v;
        in_pc_i[0]     = p0;
        in_pc_i[1]     = p1;
        in_result_i[0] = r0;
        in_result_i[1] = r1;
        pause_i        = pz;
        flush_i        = fl;
        if (fl) begin
            m_drop += mq.size();
            mq.delete();
        end else begin
            if (!m_flushing && !m_paused) begin
                e.tag = edge_cnt + 1;
                e.v   = '0;
                e.pc  = '0;
                e.res = '0;
                n_iss = 0;
                blk   = 1'b0;
                for (int k = 0; k < NP && k < mq.size(); k++) begin
                    if (!blk) begin
                        a = mq[k];
                        for (int j = 0; j < k; j++) begin
                            b = mq[j];
                            if (b.pc[IW-1:0] == a.pc[IW-1:0]) blk = 1'b1;
                        end
                        if (blk) begin
                            m_conf++;
                        end else begin
                            e.v[k]   = 1'b1;
                            e.pc[k]  = a.pc;
                            e.res[k] = a.res;
                            n_iss++;
                        end
                    end
                end
                repeat (n_iss) void'(mq.pop_front());
                if (n_iss > 0) expq.push_back(e);
            end
            if (exp_ready) begin
                if (v[0]) mq.push_back('{pc: p0, res: r0});
                if (v[1]) mq.push_back('{pc: p1, res: r1});
            end
        end
        m_flushing = fl;
        m_paused   = !fl && pz;
    endtask

    task automatic idle(input int n, input logic pz);
        repeat (n) step('0, '0, '0, '0, '0, pz, 1'b0);
    endtask

    task automatic rand_step();
        logic [31:0] p0;
        logic [31:0] p1;
        logic        fl;
        if ($urandom_range(0, 15) == 0) r_pause = !r_pause;
        fl = ($urandom_range(0, 29) == 0) && !m_flushing;
        p0 = ($urandom_range(0, 7) << 11) | ($urandom_range(0, 3) << 2);
        p1 = ($urandom_range(0, 7) << 11) | ($urandom_range(0, 3) << 2);
        step(2'($urandom), p0, p1, $urandom, $urandom, r_pause, fl);
    endtask

    task automatic mid_reset();
        @(negedge clk_i);
        rst_i      = 1'b1;
        in_valid_i = '0;
        pause_i    = 1'b0;
        flush_i    = 1'b0;
        r_pause    = 1'b0;
        mq.delete();
        expq.delete();
        m_flushing = 1'b0;
        m_paused   = 1'b0;
        m_conf     = 0;
        m_drop     = 0;
        #1;
        check("async_rst_valid", 32'(fb_valid_o), 32'd0);
        check("async_rst_count", 32'(fifo_count_o), 32'd0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    // Monitor: every presented issue group must match the oldest expected one, on time.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i);
            #2;
            if (rst_i) continue;
            while (expq.size() > 0 && expq[0].tag < edge_cnt) begin
                e = expq.pop_front();
                check("issue_missing", 32'(fb_valid_o), 32'(e.v));
            end
            if (fb_valid_o != '0) begin
                if (expq.size() == 0 || expq[0].tag != edge_cnt) begin
                    check("fb_valid_spurious", 32'(fb_valid_o), 32'd0);
                end else begin
                    e = expq.pop_front();
                    $display("issue edge=%0d valid=%b pc0=%08h pc1=%08h", edge_cnt, fb_valid_o,
                             fb_pc_o[0], fb_pc_o[1]);
                    check("fb_valid", 32'(fb_valid_o), 32'(e.v));
                    for (int k = 0; k < NP; k++) begin
                        if (e.v[k]) begin
                            check("fb_pc", fb_pc_o[k], e.pc[k]);
                            check("fb_result", fb_result_o[k], e.res[k]);
                        end
                    end
                end
            end
        end
    end

    initial begin
        in_valid_i  = '0;
        in_pc_i     = '0;
        in_result_i = '0;
        pause_i     = 1'b0;
        flush_i     = 1'b0;
        repeat (3) @(negedge clk_i);
        check("rst_fb_valid", 32'(fb_valid_o), 32'd0);
        check("rst_fb_pc0", fb_pc_o[0], 32'd0);
        check("rst_fb_result1", fb_result_o[1], 32'd0);
        check("rst_count", 32'(fifo_count_o), 32'd0);
        rst_i = 1'b0;

        // distinct indices
        step(2'b11, 32'h100, 32'h104, 32'd5, 32'd6, 1'b0, 1'b0);
        idle(4, 1'b0);
        // same-index conflict
        step(2'b11, 32'h800, 32'h1000, 32'd7, 32'd8, 1'b0, 1'b0);
        idle(4, 1'b0);
        // fill to full while paused, fifth push refused, then drain
        for (int i = 0; i < 5; i++)
            step(2'b11, 32'h2000 + 32'(i * 16), 32'h2008 + 32'(i * 16),
                 32'(i * 2), 32'(i * 2 + 1), 1'b1, 1'b0);
        idle(2, 1'b1);
        idle(6, 1'b0);
        // pause with three entries buffered
        step(2'b11, 32'h300, 32'h304, 32'd11, 32'd12, 1'b1, 1'b0);
        step(2'b01, 32'h308, 32'h0, 32'd13, 32'd0, 1'b1, 1'b0);
        idle(3, 1'b1);
        idle(4, 1'b0);
        // flush with five buffered entries and a simultaneous push
        step(2'b11, 32'h400, 32'h404, 32'd1, 32'd2, 1'b1, 1'b0);
        step(2'b11, 32'h408, 32'h40c, 32'd3, 32'd4, 1'b1, 1'b0);
        step(2'b01, 32'h410, 32'h0, 32'd5, 32'd0, 1'b1, 1'b0);
        step(2'b11, 32'h500, 32'h504, 32'd9, 32'd9, 1'b0, 1'b1);
        idle(4, 1'b0);

        repeat (500) rand_step();
        mid_reset();
        step('0, '0, '0, '0, '0, 1'b0, 1'b0);
        repeat (200) rand_step();
        idle(12, 1'b0);

        check("drain_expected", expq.size(), 32'd0);
        check("drain_model", 32'(fifo_count_o), mq.size());
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
